// File: rtl/mem_word_backend_if.sv
// Memory-side bus between the coherency controller (master) and
// mem_word_backend (slave). One word per request, completion by a
// single-cycle mem_ready pulse.
interface mem_word_backend_if;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  modport master (
    output mem_req, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_busy, mem_err
  );

  modport slave (
    input  mem_req, mem_rw, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_busy, mem_err
  );
endinterface

// File: rtl/mem_word_backend.sv
// Word-granular backing memory behind the MESI controller.
// Each request is latched in IDLE, waits a fixed LATENCY via a down-counter,
// commits the access when the count reaches zero and answers with a one-cycle
// mem_ready pulse.
// Optional macro MEM_ADDR_CHECK_EN: flag misaligned / out-of-range addresses
// with mem_err, suppress the write and return 32'hDEADBEEF for reads.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for mem_req; request fields latched on acceptance
// ST_WAIT | latency countdown; access committed on the edge cnt == 0
// ST_RESP | mem_ready (and mem_err) high for this single cycle
module mem_word_backend #(
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_word_backend_if.slave bus
);
  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             w_accept;
  logic             w_access;
  logic             w_addr_err;

  logic             r_rw;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic             r_err;

  logic [31:0]      r_rdata;
  logic             r_ready;
  logic             r_err_out;

  logic [31:0]      r_mem [DEPTH_WORDS];

`ifdef MEM_ADDR_CHECK_EN
  // Range check reduces to "any bit above the index field set" since depth is a power of two.
  assign w_addr_err = (bus.mem_addr[1:0] != 2'b00) || (bus.mem_addr[31:2+IDX_W] != '0);
`else
  assign w_addr_err = 1'b0;
`endif

  // Byte-offset and alias bits take no part in the default datapath.
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.mem_addr[1:0], bus.mem_addr[31:2+IDX_W]};

  // Next-state, counter and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mem_req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request fields once, at acceptance; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rw    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rw    <= bus.mem_rw;
      r_idx   <= bus.mem_addr[2 +: IDX_W];
      r_wdata <= bus.mem_wdata;
      r_err   <= w_addr_err;
    end
  end

  // Registered response: ready/err pulse and read data, all updated on the access edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ready   <= 1'b0;
      r_err_out <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_ready   <= w_access;
      r_err_out <= w_access & r_err;
      if (w_access && !r_rw) begin
        r_rdata <= r_err ? 32'hDEADBEEF : r_mem[r_idx];
      end
    end
  end

  // Storage is never reset; a reset edge still blocks the commit of an in-flight write.
  always_ff @(posedge clk) begin
    if (reset_n && w_access && r_rw && !r_err) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.mem_ready = r_ready;
  assign bus.mem_err   = r_err_out;
  assign bus.mem_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_word_backend.sv
// Bench for mem_word_backend: directed scenarios plus randomized traffic
// checked against a word-indexed reference memory.
module tb_mem_word_backend;
  localparam int DEPTH = 16384;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata;

  mem_word_backend_if bus ();

  mem_word_backend #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog run did not complete");
    $fatal(1, "watchdog");
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic bit exp_err(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
`else
    return (a === 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Issue one request, drop/scramble the bus right after sampling, time the response.
  task automatic do_txn(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err, output int lat,
                        output logic busy_after);
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_rw = rw; bus.mem_addr = addr; bus.mem_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0; bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
    bus.mem_rw = 1'($urandom_range(0, 1));
    lat = 0; rd = 32'h0; err = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_ready === 1'b1) begin
        lat = n; rd = bus.mem_rdata; err = bus.mem_err;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
    busy_after = bus.mem_busy;
  endtask

  // Write through the DUT and mirror it in the model (no checks).
  task automatic preload(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd; bit e; int l; logic b;
    do_txn(1'b1, addr, wd, rd, e, l, b);
    if (!exp_err(addr)) ref_mem[widx(addr)] = wd;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.mem_req = 1'b0; bus.mem_rw = 1'b0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.mem_ready); end
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.mem_busy); end
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.mem_rdata); end
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.mem_err); end
    reset_n = 1'b1;
    ref_rdata = 32'h0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; bit e; int l; logic b;
    do_txn(1'b1, 32'h40, 32'hCAFEF00D, rd, e, l, b);
    ref_mem[widx(32'h40)] = 32'hCAFEF00D;
    checks++; if (l != LAT) begin errors++; $display("FAIL wr_latency got %0d exp %0d", l, LAT); end
    checks++; if (rd !== ref_rdata) begin errors++; $display("FAIL wr_rdata_hold got %h exp %h", rd, ref_rdata); end
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL wr_busy_fall got %b exp 0", b); end
    do_txn(1'b0, 32'h40, 32'h0, rd, e, l, b);
    checks++; if (l != LAT) begin errors++; $display("FAIL rd_latency got %0d exp %0d", l, LAT); end
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data got %h exp cafef00d", rd); end
    ref_rdata = 32'hCAFEF00D;
  endtask

  task automatic test_line_fill();
    int cyc, cnt;
    int t [4];
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4 * i), 32'h11 * 32'(i + 1));
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_rw = 1'b0; bus.mem_addr = 32'h100; bus.mem_wdata = 32'h0;
    cyc = 0; cnt = 0;
    for (int n = 0; n < 100 && cnt < 4; n++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.mem_ready === 1'b1) begin
        t[cnt] = cyc; d[cnt] = bus.mem_rdata; cnt++;
        if (cnt == 4) bus.mem_req = 1'b0;
        else bus.mem_addr = bus.mem_addr + 32'd4;
      end
    end
    bus.mem_req = 1'b0;
    checks++; if (cnt != 4) begin errors++; $display("FAIL fill_count got %0d exp 4", cnt); end
    for (int i = 0; i < 4; i++) begin
      if (i < cnt) begin
        checks++;
        if (d[i] !== 32'h11 * 32'(i + 1)) begin errors++; $display("FAIL fill_data%0d got %h exp %h", i, d[i], 32'h11 * 32'(i + 1)); end
      end
      if (i > 0 && i < cnt) begin
        checks++;
        if (t[i] - t[i-1] != LAT + 2) begin errors++; $display("FAIL fill_gap%0d got %0d exp %0d", i, t[i] - t[i-1], LAT + 2); end
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL fill_busy_end got %b exp 0", bus.mem_busy); end
    ref_rdata = 32'h44;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; bit e; int l; logic b;
    int pulses;
    preload(32'h80, 32'h9);
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_rw = 1'b1; bus.mem_addr = 32'h80; bus.mem_wdata = 32'h5;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ref_rdata = 32'h0;
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", bus.mem_busy); end
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata got %h exp 0", bus.mem_rdata); end
    pulses = (bus.mem_ready === 1'b1) ? 1 : 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_ready === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_pulses got %0d exp 0", pulses); end
    do_txn(1'b0, 32'h80, 32'h0, rd, e, l, b);
    checks++; if (rd !== 32'h9) begin errors++; $display("FAIL rst_mid_readback got %h exp 9", rd); end
    ref_rdata = 32'h9;
  endtask

  task automatic test_dropped_req();
    int pulses;
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_rw = 1'b0; bus.mem_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_ready === 1'b1) pulses++;
    end
    ref_rdata = ref_mem[widx(32'h40)];
    checks++; if (pulses != 1) begin errors++; $display("FAIL drop_pulses got %0d exp 1", pulses); end
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b exp 0", bus.mem_busy); end
    checks++; if (bus.mem_rdata !== ref_rdata) begin errors++; $display("FAIL drop_rdata got %h exp %h", bus.mem_rdata, ref_rdata); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd; bit e, ee; int l; logic b; bit rw;
    for (int i = 0; i < 32; i++) preload(32'(i * 4), $urandom);
    for (int k = 0; k < 60; k++) begin
      a = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << 16);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      rw = 1'($urandom_range(0, 1));
      wd = $urandom;
      ee = exp_err(a);
      do_txn(rw, a, wd, rd, e, l, b);
      if (rw) begin
        exp_rd = ref_rdata;
        if (!ee) ref_mem[widx(a)] = wd;
      end else begin
        exp_rd = ee ? 32'hDEADBEEF : ref_mem[widx(a)];
        ref_rdata = exp_rd;
      end
      checks++; if (l != LAT) begin errors++; $display("FAIL rand_latency k=%0d got %0d exp %0d", k, l, LAT); end
      checks++; if (e !== ee) begin errors++; $display("FAIL rand_err k=%0d addr=%h got %b exp %b", k, a, e, ee); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata k=%0d rw=%b addr=%h got %h exp %h", k, rw, a, rd, exp_rd); end
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL rand_busy k=%0d got %b exp 0", k, b); end
    end
  endtask

  task automatic test_addr_check();
    logic [31:0] rd; bit e; int l; logic b;
    logic [31:0] word0;
    preload(32'h0, 32'h1234_5678);
    word0 = ref_mem[0];
`ifdef MEM_ADDR_CHECK_EN
    do_txn(1'b0, 32'h2, 32'h0, rd, e, l, b);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL chk_misalign_err got %b exp 1", e); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL chk_misalign_rdata got %h exp deadbeef", rd); end
    checks++; if (l != LAT) begin errors++; $display("FAIL chk_misalign_latency got %0d exp %0d", l, LAT); end
    do_txn(1'b1, 32'(DEPTH * 4), 32'h7, rd, e, l, b);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL chk_range_err got %b exp 1", e); end
    do_txn(1'b0, 32'h0, 32'h0, rd, e, l, b);
    checks++; if (rd !== word0) begin errors++; $display("FAIL chk_word0 got %h exp %h", rd, word0); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL chk_word0_err got %b exp 0", e); end
`else
    do_txn(1'b1, 32'(DEPTH * 4), 32'h7, rd, e, l, b);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL alias_wr_err got %b exp 0 (prev %h)", e, word0); end
    do_txn(1'b0, 32'h0, 32'h0, rd, e, l, b);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL alias_word0 got %h exp 7", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL alias_rd_err got %b exp 0", e); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_line_fill();
    test_reset_mid_write();
    test_dropped_req();
    test_random();
    test_addr_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
